// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and drives a req/ack instruction memory.
// It also selects the next PC, applies decode stalls and squashes fetches made stale by a redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BOOT_DELAY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hazard,
    input  logic        BranchTaken,
    input  logic [31:0] PCBranch,
    input  logic        jump,
    input  logic [31:0] jumpAddress,
    input  logic        jump_reg,
    input  logic [31:0] jumpReg,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrucao,
    output logic [31:0] contador,
    output logic        if_valid,
    output logic [1:0]  pc_sel
);

    // state | meaning
    // BOOT  | waiting BOOT_DELAY cycles for imem to load, no requests
    // ISSUE | request outstanding at addr_q
    // DRAIN | stale request outstanding, redirect target latched
    // HOLD  | decode stalled, outputs frozen, no requests
    localparam logic [1:0] BOOT  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;
    localparam logic [1:0] HOLD  = 2'b11;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_DELAY - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cont_q, cont_d;
    logic        valid_q, valid_d;
    logic [1:0]  pc_sel_q, pc_sel_d;
    logic [31:0] tgt_q, tgt_d;
    logic [1:0]  tgt_sel_q, tgt_sel_d;

    logic        redirect;
    logic [31:0] redir_tgt;
    logic [1:0]  redir_sel;
    logic        br_override;
    logic [31:0] addr_inc;

    assign redirect = BranchTaken | jump_reg | jump;
    assign addr_inc = addr_q + 32'd4;

    always_comb begin
        redir_tgt = {jumpAddress[31:2], 2'b00};
        redir_sel = SEL_J;
        if (BranchTaken) begin
            redir_tgt = {PCBranch[31:2], 2'b00};
            redir_sel = SEL_BR;
        end else if (jump_reg) begin
            redir_tgt = {jumpReg[31:2], 2'b00};
            redir_sel = SEL_JR;
        end
    end

    // While draining, only a branch may replace a latched jump/jump_reg target.
    assign br_override = BranchTaken && (tgt_sel_q != SEL_BR);

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        cont_d     = cont_q;
        valid_d    = valid_q;
        pc_sel_d   = pc_sel_q;
        tgt_d      = tgt_q;
        tgt_sel_d  = tgt_sel_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ISSUE;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end
            ISSUE: begin
                if (imem_ack && !redirect) begin
                    instr_d  = imem_rdata;
                    cont_d   = addr_inc;
                    valid_d  = 1'b1;
                    pc_sel_d = SEL_SEQ;
                    if (hazard) begin
                        state_d = HOLD;
                    end else begin
                        addr_d = addr_inc;
                    end
                end else if (imem_ack && redirect) begin
                    valid_d  = 1'b0;
                    addr_d   = redir_tgt;
                    pc_sel_d = redir_sel;
                end else if (redirect) begin
                    valid_d   = 1'b0;
                    tgt_d     = redir_tgt;
                    tgt_sel_d = redir_sel;
                    pc_sel_d  = redir_sel;
                    state_d   = DRAIN;
                end else if (!hazard) begin
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                if (br_override) begin
                    tgt_d     = {PCBranch[31:2], 2'b00};
                    tgt_sel_d = SEL_BR;
                    pc_sel_d  = SEL_BR;
                end
                if (imem_ack) begin
                    addr_d  = br_override ? {PCBranch[31:2], 2'b00} : tgt_q;
                    state_d = ISSUE;
                end
            end
            default: begin
                if (redirect) begin
                    valid_d  = 1'b0;
                    addr_d   = redir_tgt;
                    pc_sel_d = redir_sel;
                    state_d  = ISSUE;
                end else if (!hazard) begin
                    addr_d  = cont_q;
                    state_d = ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= 8'd0;
            addr_q     <= RESET_PC;
            instr_q    <= 32'd0;
            cont_q     <= RESET_PC + 32'd4;
            valid_q    <= 1'b0;
            pc_sel_q   <= SEL_SEQ;
            tgt_q      <= 32'd0;
            tgt_sel_q  <= SEL_SEQ;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            cont_q     <= cont_d;
            valid_q    <= valid_d;
            pc_sel_q   <= pc_sel_d;
            tgt_q      <= tgt_d;
            tgt_sel_q  <= tgt_sel_d;
        end
    end

    assign imem_req  = (state_q == ISSUE) || (state_q == DRAIN);
    assign imem_addr = addr_q;
    assign instrucao = instr_q;
    assign contador  = cont_q;
    assign if_valid  = valid_q;
    assign pc_sel    = pc_sel_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory returns its own address as data.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hazard = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] PCBranch = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jumpAddress = 32'd0;
    logic        jump_reg = 1'b0;
    logic [31:0] jumpReg = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instrucao;
    logic [31:0] contador;
    logic        if_valid;
    logic [1:0]  pc_sel;

    logic auto_ack = 1'b1;
    logic manual_ack = 1'b0;
    int   checks = 0;
    int   errors = 0;

    assign imem_ack   = auto_ack ? imem_req : manual_ack;
    assign imem_rdata = imem_addr;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .BOOT_DELAY(4)) dut (
        .clock(clock), .reset(reset), .hazard(hazard),
        .BranchTaken(BranchTaken), .PCBranch(PCBranch),
        .jump(jump), .jumpAddress(jumpAddress),
        .jump_reg(jump_reg), .jumpReg(jumpReg),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instrucao(instrucao), .contador(contador),
        .if_valid(if_valid), .pc_sel(pc_sel)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        checks++; if (instrucao !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instrucao); end
        checks++; if (contador !== 32'h4) begin errors++; $display("FAIL rst_cont: got %h exp 4", contador); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", if_valid); end
        checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL rst_pcsel: got %b exp 00", pc_sel); end
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (imem_req !== (k == 4)) begin
                errors++; $display("FAIL boot_req cycle %0d: got %b exp %b", k, imem_req, (k == 4));
            end
        end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL boot_addr: got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        step();
        checks++; if (instrucao !== 32'h0 || if_valid !== 1'b1 || contador !== 32'h4) begin
            errors++; $display("FAIL stream0: got %h/%b/%h exp 0/1/4", instrucao, if_valid, contador); end
        step();
        checks++; if (instrucao !== 32'h4 || contador !== 32'h8) begin
            errors++; $display("FAIL stream4: got %h/%h exp 4/8", instrucao, contador); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stream_addr: got %h exp 8", imem_addr); end
    endtask

    task automatic test_hazard();
        hazard = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (instrucao !== 32'h8 || if_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL hazard_hold %0d: got %h/%b/%b exp 8/1/0", k, instrucao, if_valid, imem_req); end
        end
        hazard = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL hazard_resume: got %b/%h exp 1/c", imem_req, imem_addr); end
        step();
        checks++; if (instrucao !== 32'hC || contador !== 32'h10) begin
            errors++; $display("FAIL hazard_next: got %h/%h exp c/10", instrucao, contador); end
    endtask

    task automatic test_branch_drain();
        auto_ack = 1'b0; manual_ack = 1'b0;
        BranchTaken = 1'b1; PCBranch = 32'h40;
        step();
        BranchTaken = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10 || pc_sel !== 2'b01) begin
            errors++; $display("FAIL drain_enter: got %b/%b/%h/%b exp 0/1/10/01", if_valid, imem_req, imem_addr, pc_sel); end
        repeat (2) step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL drain_wait: got %b/%h exp 1/10", imem_req, imem_addr); end
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        checks++; if (imem_addr !== 32'h40 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL drain_exit: got %h/%b/%b exp 40/0/1", imem_addr, if_valid, imem_req); end
        auto_ack = 1'b1;
        step();
        checks++; if (instrucao !== 32'h40 || if_valid !== 1'b1 || contador !== 32'h44) begin
            errors++; $display("FAIL branch_fetch: got %h/%b/%h exp 40/1/44", instrucao, if_valid, contador); end
    endtask

    task automatic test_priority();
        BranchTaken = 1'b1; PCBranch = 32'h100;
        jump_reg = 1'b1; jumpReg = 32'h300;
        jump = 1'b1; jumpAddress = 32'h200;
        step();
        checks++; if (imem_addr !== 32'h100 || pc_sel !== 2'b01 || if_valid !== 1'b0) begin
            errors++; $display("FAIL prio_all: got %h/%b/%b exp 100/01/0", imem_addr, pc_sel, if_valid); end
        BranchTaken = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h300 || pc_sel !== 2'b11) begin
            errors++; $display("FAIL prio_jr: got %h/%b exp 300/11", imem_addr, pc_sel); end
        jump_reg = 1'b0; jumpAddress = 32'h203;
        step();
        checks++; if (imem_addr !== 32'h200 || pc_sel !== 2'b10) begin
            errors++; $display("FAIL prio_j_align: got %h/%b exp 200/10", imem_addr, pc_sel); end
        jump = 1'b0;
        step();
        checks++; if (instrucao !== 32'h200 || pc_sel !== 2'b00 || imem_addr !== 32'h204) begin
            errors++; $display("FAIL prio_fetch: got %h/%b/%h exp 200/00/204", instrucao, pc_sel, imem_addr); end
    endtask

    task automatic test_hold_redirect();
        hazard = 1'b1;
        step();
        checks++; if (instrucao !== 32'h204 || imem_req !== 1'b0) begin
            errors++; $display("FAIL hold_enter: got %h/%b exp 204/0", instrucao, imem_req); end
        jump_reg = 1'b1; jumpReg = 32'h80;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_valid !== 1'b0 || pc_sel !== 2'b11) begin
            errors++; $display("FAIL hold_redirect: got %b/%h/%b/%b exp 1/80/0/11", imem_req, imem_addr, if_valid, pc_sel); end
        jump_reg = 1'b0; hazard = 1'b0;
        step();
        checks++; if (instrucao !== 32'h80 || if_valid !== 1'b1) begin
            errors++; $display("FAIL hold_fetch: got %h/%b exp 80/1", instrucao, if_valid); end
    endtask

    task automatic test_drain_overwrite();
        auto_ack = 1'b0; manual_ack = 1'b0;
        jump = 1'b1; jumpAddress = 32'h500;
        step();
        jump = 1'b0;
        jump_reg = 1'b1; jumpReg = 32'h700;
        step();
        jump_reg = 1'b0;
        checks++; if (pc_sel !== 2'b10 || imem_addr !== 32'h84) begin
            errors++; $display("FAIL drain_ignore_jr: got %b/%h exp 10/84", pc_sel, imem_addr); end
        BranchTaken = 1'b1; PCBranch = 32'h600;
        step();
        BranchTaken = 1'b0;
        checks++; if (pc_sel !== 2'b01) begin errors++; $display("FAIL drain_br_sel: got %b exp 01", pc_sel); end
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        checks++; if (imem_addr !== 32'h600 || if_valid !== 1'b0) begin
            errors++; $display("FAIL drain_br_target: got %h/%b exp 600/0", imem_addr, if_valid); end
    endtask

    task automatic test_reset_in_drain();
        jump = 1'b1; jumpAddress = 32'h900;
        step();
        jump = 1'b0;
        checks++; if (imem_addr !== 32'h600 || imem_req !== 1'b1) begin
            errors++; $display("FAIL pre_reset_drain: got %h/%b exp 600/1", imem_addr, imem_req); end
        reset = 1'b0;
        step();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instrucao !== 32'h0 || contador !== 32'h4 || if_valid !== 1'b0 || pc_sel !== 2'b00) begin
            errors++; $display("FAIL mid_reset: got %b/%h/%h/%h/%b/%b exp 0/0/0/4/0/00", imem_req, imem_addr, instrucao, contador, if_valid, pc_sel); end
        reset = 1'b1; auto_ack = 1'b1;
        repeat (4) step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reboot: got %b/%h exp 1/0", imem_req, imem_addr); end
        step();
        checks++; if (instrucao !== 32'h0 || if_valid !== 1'b1 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL reboot_fetch: got %h/%b/%h exp 0/1/4", instrucao, if_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jumpAddress = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
        step();
        checks++; if (instrucao !== 32'hFFFF_FFFC || contador !== 32'h0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_edge: got %h/%h/%h exp fffffffc/0/0", instrucao, contador, imem_addr); end
        step();
        checks++; if (instrucao !== 32'h0 || contador !== 32'h4) begin
            errors++; $display("FAIL wrap_zero: got %h/%h exp 0/4", instrucao, contador); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hazard();
        test_branch_drain();
        test_priority();
        test_hold_redirect();
        test_drain_overwrite();
        test_reset_in_drain();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
